// File: rtl/touch_key_pkg.sv
// Shared defaults, mode encoding and key-number helpers for the touch key scanner.
package touch_key_pkg;

  localparam int DEF_NUM_KEYS        = 8;
  localparam int DEF_COORD_W         = 10;
  localparam int DEF_COLOR_W         = 8;
  localparam int DEF_THRESH          = 8'hAF;
  localparam int DEF_DEBOUNCE_FRAMES = 3;
  localparam int MAX_KEYS            = 15;
  localparam int KEY_IDX_W           = 4;
  localparam int CNT_W               = 4;

  typedef enum logic {
    MODE_PLAY   = 1'b0,
    MODE_RECORD = 1'b1
  } mode_e;

  // Key numbers are 1-based; key 0 means "no key" and maps to an empty mask.
  function automatic logic [MAX_KEYS-1:0] key_to_bit(input logic [KEY_IDX_W-1:0] key);
    logic [MAX_KEYS-1:0] mask;
    if (key != 4'd0) begin
      mask = 15'd1 << (key - 4'd1);
    end else begin
      mask = '0;
    end
    return mask;
  endfunction

endpackage

// File: rtl/touch_key_debounce.sv
// Per-key frame debouncer: consecutive hit/miss frames drive the pressed state.
module touch_key_debounce
  import touch_key_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic frame_tick_i,
  input  logic hit_i,
  output logic pressed_o,
  output logic press_pulse_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_FRAMES);

  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_s;

  always_comb begin
    press_cnt_d   = press_cnt_q;
    rel_cnt_d     = rel_cnt_q;
    pressed_d     = pressed_q;
    press_pulse_s = 1'b0;
    if (clear_i) begin
      press_cnt_d = '0;
      rel_cnt_d   = '0;
      pressed_d   = 1'b0;
    end else if (frame_tick_i) begin
      if (hit_i) begin
        rel_cnt_d   = '0;
        press_cnt_d = (press_cnt_q < LIMIT) ? press_cnt_q + 4'd1 : press_cnt_q;
        if (!pressed_q && (press_cnt_d == LIMIT)) begin
          pressed_d     = 1'b1;
          press_pulse_s = 1'b1;
        end else begin
          pressed_d     = pressed_q;
        end
      end else begin
        press_cnt_d = '0;
        rel_cnt_d   = (rel_cnt_q < LIMIT) ? rel_cnt_q + 4'd1 : rel_cnt_q;
        if (pressed_q && (rel_cnt_d == LIMIT)) begin
          pressed_d = 1'b0;
        end else begin
          pressed_d = pressed_q;
        end
      end
    end else begin
      pressed_d = pressed_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_cnt_q <= '0;
      rel_cnt_q   <= '0;
      pressed_q   <= 1'b0;
    end else begin
      press_cnt_q <= press_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      pressed_q   <= pressed_d;
    end
  end

  assign pressed_o     = pressed_q;
  assign press_pulse_o = press_pulse_s;

endmodule

// File: rtl/touch_key_scanner.sv
// Multi-key touch scanner: calibrated pixel points are sampled each frame,
// debounced per key, and new presses are serialised as note_on events.
module touch_key_scanner
  import touch_key_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int COORD_W         = DEF_COORD_W,
  parameter int COLOR_W         = DEF_COLOR_W,
  parameter int THRESH          = DEF_THRESH,
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
  parameter int KEY_W           = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_mode,
  input  logic                i_cal_valid,
  input  logic [KEY_W-1:0]    i_cal_idx,
  input  logic                i_frame_start,
  input  logic [COORD_W-1:0]  i_x,
  input  logic [COORD_W-1:0]  i_y,
  input  logic [COLOR_W-1:0]  i_r,
  input  logic [COLOR_W-1:0]  i_g,
  input  logic [COLOR_W-1:0]  i_b,
  output logic [KEY_W-1:0]    o_sound_num,
  output logic                o_note_on,
  output logic [NUM_KEYS-1:0] o_key_state,
  output logic [NUM_KEYS-1:0] o_cal_mask
);

  localparam logic [COLOR_W-1:0] THRESH_C = COLOR_W'(THRESH);

  mode_e               mode_s;
  logic                play_s;
  logic                cal_we_s;
  logic [NUM_KEYS-1:0] cal_bit_s;
  logic                bright_s;
  logic                frame_tick_s;

  logic [COORD_W-1:0]  x_q [NUM_KEYS];
  logic [COORD_W-1:0]  x_d [NUM_KEYS];
  logic [COORD_W-1:0]  y_q [NUM_KEYS];
  logic [COORD_W-1:0]  y_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] cal_mask_q, cal_mask_d;
  logic [NUM_KEYS-1:0] hit_now_s;
  logic [NUM_KEYS-1:0] hit_q, hit_d;
  logic [NUM_KEYS-1:0] key_state_s;
  logic [NUM_KEYS-1:0] press_pulse_s;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [KEY_W-1:0]    low_idx_s;
  logic [NUM_KEYS-1:0] low_bit_s;
  logic [KEY_W-1:0]    sound_num_q, sound_num_d;
  logic                note_on_q, note_on_d;

  assign mode_s       = mode_e'(i_mode);
  assign play_s       = (mode_s == MODE_PLAY);
  assign cal_we_s     = (mode_s == MODE_RECORD) && i_cal_valid &&
                        (i_cal_idx != '0) && (i_cal_idx <= KEY_W'(NUM_KEYS));
  assign cal_bit_s    = NUM_KEYS'(key_to_bit(KEY_IDX_W'(i_cal_idx)));
  assign bright_s     = (i_r > THRESH_C) && (i_g > THRESH_C) && (i_b > THRESH_C);
  assign frame_tick_s = play_s && i_frame_start;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    cal_mask_d = cal_mask_q;
    if (cal_we_s) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (cal_bit_s[k]) begin
          x_d[k] = i_x;
          y_d[k] = i_y;
        end else begin
          x_d[k] = x_q[k];
          y_d[k] = y_q[k];
        end
      end
      cal_mask_d = cal_mask_q | cal_bit_s;
    end else begin
      cal_mask_d = cal_mask_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
      cal_mask_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      cal_mask_q <= cal_mask_d;
    end
  end

  // Keys sharing a calibrated point all hit on the same pixel.
  always_comb begin
    hit_now_s = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      hit_now_s[k] = play_s && bright_s && cal_mask_q[k] &&
                     (i_x == x_q[k]) && (i_y == y_q[k]);
    end
  end

  // The first pixel of a frame seeds the new frame's flags.
  always_comb begin
    hit_d = hit_q;
    if (!play_s) begin
      hit_d = '0;
    end else if (frame_tick_s) begin
      hit_d = hit_now_s;
    end else begin
      hit_d = hit_q | hit_now_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    touch_key_debounce #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (!play_s),
      .frame_tick_i  (frame_tick_s),
      .hit_i         (hit_q[g]),
      .pressed_o     (key_state_s[g]),
      .press_pulse_o (press_pulse_s[g])
    );
  end

  // Descending scan so the lowest pending key wins.
  always_comb begin
    low_idx_s = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        low_idx_s = KEY_W'(k + 1);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
    low_bit_s = NUM_KEYS'(key_to_bit(KEY_IDX_W'(low_idx_s)));
  end

  always_comb begin
    pending_d   = pending_q;
    note_on_d   = 1'b0;
    sound_num_d = sound_num_q;
    if (!play_s) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~low_bit_s) | press_pulse_s;
      if (pending_q != '0) begin
        note_on_d   = 1'b1;
        sound_num_d = low_idx_s;
      end else begin
        note_on_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      note_on_q   <= 1'b0;
      sound_num_q <= '0;
    end else begin
      pending_q   <= pending_d;
      note_on_q   <= note_on_d;
      sound_num_q <= sound_num_d;
    end
  end

  assign o_sound_num = sound_num_q;
  assign o_note_on   = note_on_q;
  assign o_key_state = key_state_s;
  assign o_cal_mask  = cal_mask_q;

endmodule

// File: tb/tb_touch_key_scanner.sv
// Randomised bench for touch_key_scanner against a frame-level reference model.
module tb_touch_key_scanner;

  localparam int NK        = 8;
  localparam int KW        = 4;
  localparam int DF        = 3;
  localparam int TH        = 8'hAF;
  localparam int FRAME_LEN = 16;

  logic          clk;
  logic          rst;
  logic          i_mode;
  logic          i_cal_valid;
  logic [KW-1:0] i_cal_idx;
  logic          i_frame_start;
  logic [9:0]    i_x, i_y;
  logic [7:0]    i_r, i_g, i_b;
  logic [KW-1:0] o_sound_num;
  logic          o_note_on;
  logic [NK-1:0] o_key_state;
  logic [NK-1:0] o_cal_mask;

  touch_key_scanner #(
    .NUM_KEYS        (NK),
    .COORD_W         (10),
    .COLOR_W         (8),
    .THRESH          (TH),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mode        (i_mode),
    .i_cal_valid   (i_cal_valid),
    .i_cal_idx     (i_cal_idx),
    .i_frame_start (i_frame_start),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_r           (i_r),
    .i_g           (i_g),
    .i_b           (i_b),
    .o_sound_num   (o_sound_num),
    .o_note_on     (o_note_on),
    .o_key_state   (o_key_state),
    .o_cal_mask    (o_cal_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-key calibration, frame hit, hit/miss streaks, pressed.
  int m_x [NK];
  int m_y [NK];
  bit m_cal [NK];
  bit m_hit [NK];
  int m_pc [NK];
  int m_rc [NK];
  bit m_pr [NK];
  int sch_edge [$];
  int sch_key [$];
  int last_sched;
  int edge_n;
  bit exp_note;
  int exp_sound;

  int kx [NK] = '{10, 30, 100, 60, 80, 60, 120, 0};
  int ky [NK] = '{20, 40, 50, 70, 90, 70, 120, 0};

  int n_vec;
  int n_bad;
  int note_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [NK-1:0] pack_pressed();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = m_pr[k];
    return v;
  endfunction

  function automatic logic [NK-1:0] pack_cal();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = m_cal[k];
    return v;
  endfunction

  task automatic model_clear_play();
    for (int k = 0; k < NK; k++) begin
      m_hit[k] = 1'b0;
      m_pc[k]  = 0;
      m_rc[k]  = 0;
      m_pr[k]  = 1'b0;
    end
    sch_edge.delete();
    sch_key.delete();
    last_sched = -1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_x[k]   = 0;
      m_y[k]   = 0;
      m_cal[k] = 1'b0;
    end
    model_clear_play();
    exp_note  = 1'b0;
    exp_sound = 0;
  endtask

  // Evaluate the rules for the edge about to happen, using the current inputs.
  task automatic model_edge();
    bit bright;
    bit now_hit [NK];
    int nxt;
    bright   = (i_r > TH) && (i_g > TH) && (i_b > TH);
    exp_note = 1'b0;
    if (i_mode) begin
      if (i_cal_valid && i_cal_idx >= 1 && i_cal_idx <= NK) begin
        m_x[i_cal_idx - 1]   = i_x;
        m_y[i_cal_idx - 1]   = i_y;
        m_cal[i_cal_idx - 1] = 1'b1;
      end
      model_clear_play();
    end else begin
      for (int k = 0; k < NK; k++)
        now_hit[k] = m_cal[k] && (i_x == m_x[k]) && (i_y == m_y[k]) && bright;
      if (sch_edge.size() > 0 && sch_edge[0] == edge_n) begin
        exp_note  = 1'b1;
        exp_sound = sch_key[0];
        void'(sch_edge.pop_front());
        void'(sch_key.pop_front());
      end
      for (int k = 0; k < NK; k++) begin
        if (i_frame_start) begin
          if (m_hit[k]) begin
            m_rc[k] = 0;
            if (m_pc[k] < DF) m_pc[k]++;
            if (!m_pr[k] && m_pc[k] == DF) begin
              m_pr[k] = 1'b1;
              nxt = (last_sched + 1 > edge_n + 1) ? last_sched + 1 : edge_n + 1;
              sch_edge.push_back(nxt);
              sch_key.push_back(k + 1);
              last_sched = nxt;
            end
          end else begin
            m_pc[k] = 0;
            if (m_rc[k] < DF) m_rc[k]++;
            if (m_pr[k] && m_rc[k] == DF) m_pr[k] = 1'b0;
          end
          m_hit[k] = now_hit[k];
        end else begin
          m_hit[k] = m_hit[k] | now_hit[k];
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("note_on", {31'd0, o_note_on}, {31'd0, exp_note});
    check_eq("sound_num", {28'd0, o_sound_num}, exp_sound);
    check_eq("key_state", {24'd0, o_key_state}, {24'd0, pack_pressed()});
    check_eq("cal_mask", {24'd0, o_cal_mask}, {24'd0, pack_cal()});
    if (o_note_on) note_cnt++;
    edge_n++;
  endtask

  task automatic drive(input bit mode, input bit cv, input int idx, input bit fs,
                       input int x, input int y, input logic [7:0] r, g, b);
    i_mode        = mode;
    i_cal_valid   = cv;
    i_cal_idx     = KW'(idx);
    i_frame_start = fs;
    i_x           = 10'(x);
    i_y           = 10'(y);
    i_r           = r;
    i_g           = g;
    i_b           = b;
    step();
  endtask

  task automatic drive_noise(input bit fs, input bit noisy);
    logic [7:0] r, g, b;
    r = noisy ? 8'($urandom) : 8'h00;
    g = noisy ? 8'($urandom) : 8'h00;
    b = noisy ? 8'($urandom) : 8'h00;
    drive(1'b0, 1'b0, 0, fs, $urandom_range(0, 127), $urandom_range(0, 127), r, g, b);
  endtask

  task automatic calibrate(input int idx, input int x, input int y);
    drive(1'b1, 1'b1, idx, 1'b0, x, y, 8'h00, 8'h00, 8'h00);
    if (idx >= 1 && idx <= NK) begin
      kx[idx - 1] = x;
      ky[idx - 1] = y;
    end
  endtask

  task automatic run_frame(input logic [NK-1:0] touch, input logic [7:0] cr, cg, cb,
                           input bit noisy, input bit first_hit);
    int used;
    int fk;
    fk = -1;
    if (first_hit)
      for (int k = NK - 1; k >= 0; k--) if (touch[k]) fk = k;
    if (fk >= 0) drive(1'b0, 1'b0, 0, 1'b1, kx[fk], ky[fk], cr, cg, cb);
    else         drive_noise(1'b1, noisy);
    used = 1;
    for (int k = 0; k < NK; k++) begin
      if (touch[k]) begin
        drive(1'b0, 1'b0, 0, 1'b0, kx[k], ky[k], cr, cg, cb);
        used++;
      end
    end
    while (used < FRAME_LEN) begin
      drive_noise(1'b0, noisy);
      used++;
    end
  endtask

  task automatic dark_frames(input int n);
    for (int i = 0; i < n; i++) run_frame('0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    logic [NK-1:0] held;
    n_vec = 0; n_bad = 0; note_cnt = 0; edge_n = 0;
    rst = 1'b1; i_mode = 1'b0; i_cal_valid = 1'b0; i_cal_idx = '0; i_frame_start = 1'b0;
    i_x = '0; i_y = '0; i_r = '0; i_g = '0; i_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_note_on", {31'd0, o_note_on}, 32'd0);
    check_eq("rst_key_state", {24'd0, o_key_state}, 32'd0);
    check_eq("rst_cal_mask", {24'd0, o_cal_mask}, 32'd0);
    check_eq("rst_sound_num", {28'd0, o_sound_num}, 32'd0);
    rst = 1'b0;

    // Calibration, including ignored indices and an ignored frame_start.
    calibrate(3, 100, 50);
    check_eq("cal_k3", {24'd0, o_cal_mask}, 32'h04);
    calibrate(0, 7, 7);
    calibrate(9, 8, 8);
    drive(1'b1, 1'b0, 0, 1'b1, 100, 50, 8'hFF, 8'hFF, 8'hFF);
    check_eq("cal_ignored", {24'd0, o_cal_mask}, 32'h04);
    for (int k = 1; k <= 7; k++) if (k != 3) calibrate(k, kx[k - 1], ky[k - 1]);
    check_eq("cal_seven", {24'd0, o_cal_mask}, 32'h7F);

    // Key 3 held three frames, then released by dark frames.
    base = note_cnt;
    repeat (3) run_frame(8'h04, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    dark_frames(1);
    check_eq("k3_events", note_cnt - base, 32'd1);
    check_eq("k3_sound", {28'd0, o_sound_num}, 32'd3);
    check_eq("k3_state", {24'd0, o_key_state}, 32'h04);
    dark_frames(3);
    check_eq("k3_released", {24'd0, o_key_state}, 32'h00);
    check_eq("k3_no_release_event", note_cnt - base, 32'd1);

    // Green at exactly the threshold, and bright at uncalibrated key 8's (0,0).
    base = note_cnt;
    repeat (4) run_frame(8'h04, 8'hFF, 8'hAF, 8'hFF, 1'b0, 1'b0);
    repeat (4) run_frame(8'h80, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    check_eq("no_hit_events", note_cnt - base, 32'd0);
    check_eq("no_hit_state", {24'd0, o_key_state}, 32'h00);

    // Keys 2, 5, 7 pressed together.
    base = note_cnt;
    repeat (3) run_frame(8'h52, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    dark_frames(1);
    check_eq("multi_events", note_cnt - base, 32'd3);
    check_eq("multi_last_sound", {28'd0, o_sound_num}, 32'd7);
    check_eq("multi_state", {24'd0, o_key_state}, 32'h52);
    dark_frames(3);

    // Key 1 pressed, then record mode clears, then play re-presses it.
    repeat (4) run_frame(8'h01, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check_eq("k1_state", {24'd0, o_key_state}, 32'h01);
    base = note_cnt;
    repeat (4) drive(1'b1, 1'b0, 0, 1'b0, kx[0], ky[0], 8'hFF, 8'hFF, 8'hFF);
    check_eq("rec_state", {24'd0, o_key_state}, 32'h00);
    check_eq("rec_no_event", note_cnt - base, 32'd0);
    check_eq("rec_cal_kept", {24'd0, o_cal_mask}, 32'h7F);
    repeat (4) run_frame(8'h01, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check_eq("k1_repress", note_cnt - base, 32'd1);
    check_eq("k1_repress_sound", {28'd0, o_sound_num}, 32'd1);
    dark_frames(4);

    // Random phase: slowly changing touch sets, noisy pixels, occasional recalibration.
    held = '0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 1) held = held ^ NK'(1 << $urandom_range(0, NK - 1));
      run_frame(held, 8'hFF, 8'($urandom_range(176, 255)), 8'hF0, 1'b1, 1'($urandom_range(0, 1)));
      if (f % 10 == 9) begin
        calibrate($urandom_range(0, 9), $urandom_range(0, 127), $urandom_range(0, 127));
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 8'h00, 8'h00, 8'h00);
      end
    end
    dark_frames(4);

    // Asynchronous reset mid-play with keys 1 and 3 held.
    repeat (4) run_frame(8'h05, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check_eq("pre_rst_state", {24'd0, o_key_state}, {24'd0, pack_pressed()});
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_note_on", {31'd0, o_note_on}, 32'd0);
    check_eq("arst_key_state", {24'd0, o_key_state}, 32'd0);
    check_eq("arst_cal_mask", {24'd0, o_cal_mask}, 32'd0);
    check_eq("arst_sound_num", {28'd0, o_sound_num}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) run_frame(8'h05, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/touch_key_scanner.md
Name: touch_key_scanner

Overview:
Parametrised successor to the single-frame four-point sound trigger. Stores up to NUM_KEYS calibrated pixel coordinates during record mode. In play mode it samples the VGA pixel stream at each stored point. Each key is debounced across frames, and a one-cycle note_on event with key number is emitted on every new press, serialised lowest-index-first. Sits between the VGA/camera pixel pipeline and the audio sample player.

Parameters:
NUM_KEYS, 8, number of touch points/keys (1..15)
COORD_W, 10, width of i_x/i_y
COLOR_W, 8, width of each colour channel
THRESH, 8'hAF, channel is "bright" when strictly greater than THRESH
DEBOUNCE_FRAMES, 3, consecutive frames needed to press or release (1..15)
KEY_W, $clog2(NUM_KEYS+1), width of key numbers (0 = none)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_mode  in  1  0 = play, 1 = record/calibrate
i_cal_valid  in  1  detection finished; capture i_x/i_y for i_cal_idx (record mode only)
i_cal_idx  in  KEY_W  key to calibrate, 1..NUM_KEYS; 0 or >NUM_KEYS ignored
i_frame_start  in  1  one-cycle pulse on first pixel of each frame
i_x, i_y  in  COORD_W  current pixel coordinate
i_r, i_g, i_b  in  COLOR_W  current pixel colour
o_sound_num  out  KEY_W  key number of last note event; held until the next event
o_note_on  out  1  one-cycle pulse, o_sound_num valid that cycle
o_key_state  out  NUM_KEYS  debounced pressed state, bit k-1 = key k
o_cal_mask  out  NUM_KEYS  bit set once key has been calibrated

Behaviour:
- Reset (async, rst=1): all stored coordinates 0, o_cal_mask 0, hit flags 0, debounce counters 0, o_key_state 0, pending mask 0, o_sound_num 0, o_note_on 0.
- Calibration: in a cycle with i_mode=1 and i_cal_valid=1 and a valid i_cal_idx, the coordinates of key i_cal_idx are set to {i_x,i_y} at the next edge, and its o_cal_mask bit is set. Recalibration overwrites.
- Hit detect: in play mode, key k's frame hit flag is set when all of the following hold in the same cycle: its o_cal_mask bit is set, i_x/i_y equals its stored point, and i_r, i_g and i_b are all > THRESH. Several keys may share a point; all of them hit.
- Frame boundary: on the i_frame_start cycle each key's debounce logic consumes the previous frame's hit flag. The flags are then cleared, except that the current (first) pixel's hit, if any, is recorded into the new frame.
- Debounce per key: press counter counts consecutive hit frames, release counter counts consecutive miss frames, both saturating at DEBOUNCE_FRAMES.
  - Idle key becomes pressed when press count reaches DEBOUNCE_FRAMES.
  - Pressed key releases when release count reaches DEBOUNCE_FRAMES.
  - Opposite outcome resets the respective counter.
  - o_key_state updates one cycle after i_frame_start.
- Note events: a press transition sets the key's bit in the pending mask. Each cycle with a pending bit:
  - the lowest set bit k is cleared;
  - o_note_on=1 and o_sound_num=k next cycle.
  - One event per cycle, so N simultaneous presses give N consecutive pulses.
  - New press bits OR into the mask without losing existing ones.
  - Releases produce no event.
- Mode switch to record (i_mode=1): hit flags, counters, o_key_state and the pending mask clear on the next edge. o_note_on is forced 0. Calibration data is retained.
- i_frame_start in record mode is ignored. Frames before the first i_frame_start after entering play count as partial; hits still register.

Decomposition:
- Package touch_key_pkg: default parameter constants, mode_e enum {MODE_PLAY, MODE_RECORD}, and a function for key-index-to-bit conversion.
- Sub-module touch_key_debounce: one per key via generate. Inputs are frame tick, hit, and clear. Outputs are pressed and press_pulse.
- The top level holds the coordinate registers, hit flags, and the pending-mask priority encoder.

Test Plan:
- Reset mid-play with o_key_state=8'h05 → all outputs 0 the same cycle, o_cal_mask=0.
- Record: calibrate key 3 at (100,50) → o_cal_mask=8'h04. Calibrate with idx 0 or 9 → no change.
- Play, DEBOUNCE_FRAMES=3: white pixel (FF,FF,FF) at (100,50) for 3 frames → o_note_on once with o_sound_num=3 after the 4th i_frame_start. Bit 2 of o_key_state set; 3 dark frames clear it with no event.
- Pixel (FF,AF,FF) at a key point → no hit (AF not > THRESH). Bright pixel at an uncalibrated key's default (0,0) → no hit.
- Keys 2, 5, 7 press in the same frame → three consecutive o_note_on pulses, o_sound_num 2,5,7.
- Key 1 pressed, switch i_mode=1 → o_key_state=0, no o_note_on. Return to play; calibration is preserved and key 1 re-presses after 3 frames.
